maoin_ram_loader: RTL
=====================

# maoin_ram_loader

Byte-stream loader that sits directly upstream of the system's on-chip RAM (32-bit, 13-bit word address, 5024 words, byte-enabled). It accepts an 8-bit valid/ready stream (UART/SPI bootloader side), packs bytes little-endian into 32-bit words, and writes them to the RAM through an Avalon-MM master port. Each run is started by a control pulse, ends on `in_last` or when the RAM is full, and reports its completion status.

## Interface
- `DEPTH`, 5024, RAM depth in 32-bit words
- `ADDR_W`, 13, word-address width
- `BASE_WORD`, 0, first word address written
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: pulse; begins a load run when idle
- `busy` out 1: run in progress
- `done` out 1: level; run finished; held until next accepted `start`
- `overflow` out 1: run stopped because RAM was full before `in_last`
- `word_count` out ADDR_W: words written in current/last run
- `checksum` out 32: additive sum of written words
- `in_data` in 8: stream byte
- `in_valid` in 1: byte valid
- `in_ready` out 1: loader accepts byte
- `in_last` in 1: marks final byte of image
- `avm_address` out ADDR_W: word address
- `avm_byteenable` out 4: byte lanes written
- `avm_chipselect` out 1: slave select
- `avm_write` out 1: write strobe
- `avm_writedata` out 32: packed word
- `avm_waitrequest` in 1: interconnect stall

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: `start` → FILL; clears `word_count`, `checksum`, `overflow`, `done`; address = `BASE_WORD`. `start` outside IDLE/DONE ignored; DONE accepts `start` like IDLE.
- FILL: `in_ready`=1; byte accepted on `in_valid & in_ready`; byte k (0–3) goes to lane k (`[8k+7:8k]`); lane bit set in byte mask. Fourth byte or byte with `in_last` → WRITE.
- WRITE: `avm_chipselect`=`avm_write`=1, data/mask/address stable until cycle with `avm_waitrequest`=0. Unfilled lanes: data 0, byteenable 0. On completion: address+1, `word_count`+1, mask cleared; last seen → DONE; else address == `BASE_WORD+DEPTH` → `overflow`=1, DONE; else FILL.
- Overflow check happens after the write; remaining stream bytes are not consumed (`in_ready`=0).
- `in_last` with zero pending bytes impossible (last byte always fills a lane).
- Reset (any state): all outputs 0, state IDLE, partial word discarded.

## Timing
- Reset values: every output 0 (`in_ready`, `busy`, `done`, `overflow`, counters, all `avm_*`).
- `busy`=1 in FILL/WRITE; `start` seen cycle N → `in_ready`=1 at N+1.
- Word completes in byte cycle N → `avm_write` at N+1; zero-wait throughput 4 bytes per 5 cycles.
- `done` rises the cycle after final write accepted; `word_count` and `checksum` valid same cycle.
- `in_ready` is 0 in WRITE; no byte accepted while stalled.
- Address compare uses ADDR_W+1 bits to avoid wrap.

## Configuration
- `MAOIN_LOADER_CHECKSUM_EN` defined: `checksum` += `avm_writedata` (masked lanes as 0) on each accepted write, mod 2^32.
- Not defined: no accumulator logic; `checksum` tied to 0.

## Structure
- Package `maoin_loader_pkg`: state enum, `LANES`=4, `BYTE_W`=8.
- Sub-module `maoin_byte_packer`: byte→word packing, lane mask, last flag; FSM/address/counters in top.

## Test plan
- 8 bytes 0x01..0x08, `in_last` on 8th → writes addr 0 data 0x04030201 be 0xF, addr 1 0x08070605 be 0xF; `done`=1, `word_count`=2, `overflow`=0.
- 5 bytes 0xA0..0xA4, last on 5th → second write addr 1 data 0x000000A4 be 0x1; `word_count`=2.
- `avm_waitrequest` high 3 cycles on first write → `avm_*` stable 4 cycles, `in_ready`=0, no byte lost.
- `DEPTH`=4, 20-byte stream → 4 writes (addr 0–3), `overflow`=1, `done`=1, `in_ready` stays 0.
- `reset_n` low after 6 bytes → all outputs 0 next cycle; new `start` + 4 bytes writes addr 0.
- Macro on, 8 bytes 0x01..0x08 → `checksum`=0x0C0A0806; macro off → 0.

Source files
------------

// File: rtl/maoin_loader_pkg.sv
// maoin_loader_pkg: shared loader FSM states and byte/lane geometry
package maoin_loader_pkg;
  localparam int LANES = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/maoin_byte_packer.sv
// maoin_byte_packer: packs bytes little-endian into a word with lane mask and last flag
module maoin_byte_packer
  import maoin_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic [WORD_W-1:0] data,
  output logic [LANES-1:0]  mask,
  output logic              last_seen,
  output logic              word_done
);
  logic [1:0] lane;
  assign word_done = push & ((lane == 2'(LANES - 1)) | in_last);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      mask      <= '0;
      lane      <= '0;
      last_seen <= 1'b0;
    end else if (pop | clr) begin
      data      <= '0;
      mask      <= '0;
      lane      <= '0;
      last_seen <= 1'b0;
    end else if (push) begin
      data[lane*BYTE_W +: BYTE_W] <= in_byte;
      mask[lane]                  <= 1'b1;
      lane                        <= lane + 2'd1;
      last_seen                   <= in_last;
    end
  end
endmodule

// File: rtl/maoin_ram_loader.sv
// maoin_ram_loader: byte stream to Avalon-MM RAM loader; MAOIN_LOADER_CHECKSUM_EN enables the checksum accumulator
module maoin_ram_loader
  import maoin_loader_pkg::*;
#(
  parameter int DEPTH     = 5024,
  parameter int ADDR_W    = 13,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count,
  output logic [31:0]       checksum,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest
);
  // one extra address bit so BASE_WORD+DEPTH never wraps to a valid address
  localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(BASE_WORD + DEPTH);
  state_e          state;
  logic [ADDR_W:0] addr;
  logic [ADDR_W:0] addr_nxt;
  logic            start_ok;
  logic            accept;
  logic            wr_ok;
  logic            word_done;
  logic            last_seen;
  logic            full;
  assign start_ok       = start & ((state == IDLE) | (state == DONE));
  assign in_ready       = state == FILL;
  assign busy           = (state == FILL) | (state == WRITE);
  assign avm_write      = state == WRITE;
  assign avm_chipselect = state == WRITE;
  assign avm_address    = addr[ADDR_W-1:0];
  assign accept         = in_valid & in_ready;
  assign wr_ok          = avm_write & ~avm_waitrequest;
  assign addr_nxt       = addr + (ADDR_W + 1)'(1);
  assign full           = addr_nxt == END_ADDR;
  maoin_byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .pop       (wr_ok),
    .clr       (start_ok),
    .in_byte   (in_data),
    .in_last   (in_last),
    .data      (avm_writedata),
    .mask      (avm_byteenable),
    .last_seen (last_seen),
    .word_done (word_done)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else if (start_ok) begin
      state      <= FILL;
      addr       <= (ADDR_W + 1)'(BASE_WORD);
      word_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else if (word_done) begin
      state <= WRITE;
    end else if (wr_ok) begin
      addr       <= addr_nxt;
      word_count <= word_count + ADDR_W'(1);
      state      <= (last_seen | full) ? DONE : FILL;
      done       <= last_seen | full;
      overflow   <= ~last_seen & full;
    end
  end
`ifdef MAOIN_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (wr_ok) checksum <= checksum + avm_writedata;
  end
`else
  assign checksum = '0;
`endif
endmodule
